// File: rtl/mmio_pwm_led_pkg.sv
// Shared register map, control bit positions and fade-step helpers for mmio_pwm_led.
// The fade feature itself is compiled in by MMIO_PWM_LED_FADE_EN (see mmio_pwm_led.sv).
package mmio_pwm_led_pkg;

    localparam logic [7:0] DUTY_BASE  = 8'h00;
    localparam logic [7:0] CTRL_OFF   = 8'h40;
    localparam logic [7:0] PRESC_OFF  = 8'h44;
    localparam logic [7:0] STATUS_OFF = 8'h48;
    localparam logic [7:0] FADE_OFF   = 8'h4C;

    localparam int EN_BIT    = 0;
    localparam int FADE_BITS = 8;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } fade_step_e;

    function automatic logic [7:0] duty_off(input int ch);
        return DUTY_BASE + 8'(ch << 2);
    endfunction

    // Direction that moves the active duty one step toward its shadow without overshoot.
    function automatic fade_step_e fade_dir(input logic [31:0] active, input logic [31:0] target);
        if (active < target) begin
            return STEP_UP;
        end else if (active > target) begin
            return STEP_DOWN;
        end
        return STEP_HOLD;
    endfunction

endpackage

// File: rtl/mmio_pwm_led_pwm_channel.sv
// One PWM channel: shadow/active duty pair, fade stepper, compare and registered,
// polarity-adjusted output pin.
module pwm_channel
    import mmio_pwm_led_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                load,
    input  logic                step,
    input  logic                bypass,
    input  logic                wr,
    input  logic [PWM_BITS-1:0] wdata,
    input  logic [PWM_BITS-1:0] cnt,
    output logic [PWM_BITS-1:0] shadow,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] FULL    = '1;
    localparam logic                OFF_LVL = (ACTIVE_LOW != 0);

    logic [PWM_BITS-1:0] active;
    logic                on;
    fade_step_e          dir;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (wr) begin
            shadow <= wdata;
        end
    end

    always_comb begin
        dir = fade_dir(32'(active), 32'(shadow));
    end

    // A write landing on the wrap edge goes straight into the period it starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= '0;
        end else if (wr && bypass) begin
            active <= wdata;
        end else if (load) begin
            active <= shadow;
        end else if (step) begin
            case (dir)
                STEP_UP:   active <= active + 1'b1;
                STEP_DOWN: active <= active - 1'b1;
                default:   active <= active;
            endcase
        end
    end

    // All-ones duty means a true 100% rather than 255/256.
    assign on = (active == FULL) || (cnt < active);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_out <= OFF_LVL;
        end else begin
            pwm_out <= (en && on) ? !OFF_LVL : OFF_LVL;
        end
    end

endmodule

// File: rtl/mmio_pwm_led.sv
// Memory-mapped multi-channel PWM for the board LED/RGB pins: bus decode, read mux,
// prescaler and shared PWM counter. Define MMIO_PWM_LED_FADE_EN to build the FADE register.
module mmio_pwm_led
    import mmio_pwm_led_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [7:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [7:0]            off;
    logic                  wr;
    logic                  rd;
    logic                  ctrl_wr;
    logic                  presc_wr;
    logic [NUM_CH-1:0]     duty_wr;
    logic                  en;
    logic                  en_q;
    logic [PRESC_BITS-1:0] presc;
    logic [PRESC_BITS-1:0] presc_cnt;
    logic [PWM_BITS-1:0]   cnt;
    logic                  tick;
    logic                  wrap;
    logic                  load_wrap;
    logic                  load;
    logic                  step;
    logic [31:0]           fade_rd;
    logic [31:0]           rd_mux;
    logic [PWM_BITS-1:0]   shadow [NUM_CH];
    logic                  unused_bits;

    assign unused_bits = &{1'b0, addr[1:0], wdata};

    assign off      = {addr[7:2], 2'b00};
    assign wr       = sel && we;
    assign rd       = sel && !we;
    assign ctrl_wr  = wr && (off == CTRL_OFF);
    assign presc_wr = wr && (off == PRESC_OFF);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_dec
        assign duty_wr[i] = wr && (off == duty_off(i));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en    <= 1'b0;
            en_q  <= 1'b0;
            presc <= '0;
        end else begin
            en_q <= en;
            if (ctrl_wr) begin
                en <= wdata[EN_BIT];
            end
            if (presc_wr) begin
                presc <= wdata[PRESC_BITS-1:0];
            end
        end
    end

    assign tick = en && (presc_cnt == presc);
    assign wrap = tick && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt   <= '0;
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            if (!en || presc_wr || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
            if (!en) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
            period_tick <= wrap;
        end
    end

`ifdef MMIO_PWM_LED_FADE_EN
    logic [FADE_BITS-1:0] fade;
    logic [FADE_BITS-1:0] fade_cnt;
    logic                 fade_wr;
    logic                 fade_hit;

    assign fade_wr  = wr && (off == FADE_OFF);
    assign fade_hit = ({1'b0, fade_cnt} + 1'b1) >= {1'b0, fade};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fade     <= '0;
            fade_cnt <= '0;
        end else begin
            if (fade_wr) begin
                fade <= wdata[FADE_BITS-1:0];
            end
            if (!en) begin
                fade_cnt <= '0;
            end else if (wrap) begin
                fade_cnt <= ((fade == '0) || fade_hit) ? '0 : fade_cnt + 1'b1;
            end
        end
    end

    // FADE=0 degenerates to the plain load-at-wrap behaviour, bypass included.
    assign load_wrap = wrap && (fade == '0);
    assign step      = wrap && (fade != '0) && fade_hit;
    assign fade_rd   = 32'(fade);
`else
    assign load_wrap = wrap;
    assign step      = 1'b0;
    assign fade_rd   = '0;
`endif

    // While disabled (and on the first enabled cycle) active tracks shadow, so the
    // first compare after enabling already uses the programmed duty.
    assign load = !en_q || load_wrap;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .en     (en),
            .load   (load),
            .step   (step),
            .bypass (load_wrap),
            .wr     (duty_wr[i]),
            .wdata  (wdata[PWM_BITS-1:0]),
            .cnt    (cnt),
            .shadow (shadow[i]),
            .pwm_out(pwm_out[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            CTRL_OFF:   rd_mux[EN_BIT] = en;
            PRESC_OFF:  rd_mux[PRESC_BITS-1:0] = presc;
            STATUS_OFF: rd_mux[PWM_BITS-1:0] = cnt;
            FADE_OFF:   rd_mux = fade_rd;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (off == duty_off(i)) begin
                        rd_mux[PWM_BITS-1:0] = shadow[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd) begin
                rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_mmio_pwm_led.sv
// Directed bench for mmio_pwm_led (default build, 4 channels, 8-bit PWM, active-low pins).
// Read expectations go through a scoreboard queue popped when rvalid is seen.
module tb_mmio_pwm_led;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        sel   = 1'b0;
    logic        we    = 1'b0;
    logic [7:0]  addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [3:0]  pwm_out;
    logic        period_tick;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] mon_exp;
    string       mon_tag;
    int          on_cnt [4];
    int          tick_cnt;
    int          per [2];
    int          gap;

    always #5 clk = ~clk;

    mmio_pwm_led dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check(mon_tag, rdata, mon_exp);
            end
        end
    end

    // Bus tasks are entered at a falling edge and return at the next one.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [31:0] e, input string tag);
        sel = 1'b1; we = 1'b0; addr = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (period_tick !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_tick_seen"}, 32'(period_tick), 32'd1);
    endtask

    task automatic measure(input int ncyc);
        for (int c = 0; c < 4; c++) on_cnt[c] = 0;
        tick_cnt = 0;
        repeat (ncyc) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (pwm_out[c] === 1'b0) on_cnt[c]++;
            if (period_tick === 1'b1) tick_cnt++;
        end
    endtask

    // Counts ch3 on-cycles over two periods after a wrap; a duty write to ch3 is
    // issued at loop index wr_k (the cycle the counter equals wr_k+1).
    task automatic two_periods(input int wr_k, input logic [31:0] d);
        per[0] = 0; per[1] = 0;
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            if (pwm_out[3] === 1'b0) per[k / 256]++;
            if (k == wr_k) begin
                sel = 1'b1; we = 1'b1; addr = 8'h0C; wdata = d;
            end else if (k == wr_k + 1) begin
                sel = 1'b0; we = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_pwm", 32'(pwm_out), 32'hF);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_tick", 32'(period_tick), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        bus_write(8'h00, 32'hFF);
        bus_write(8'h04, 32'h40);
        bus_write(8'h08, 32'h00);
        bus_write(8'h0C, 32'h80);
        bus_write(8'h40, 32'h1);
        repeat (4) @(negedge clk);
        measure(512);
        check("ratio_ch0_full", 32'(on_cnt[0]), 32'd512);
        check("ratio_ch1_64", 32'(on_cnt[1]), 32'd128);
        check("ratio_ch2_zero", 32'(on_cnt[2]), 32'd0);
        check("ratio_ch3_128", 32'(on_cnt[3]), 32'd256);
        check("ratio_ticks", 32'(tick_cnt), 32'd2);

        bus_read(8'h04, 32'h40, "rd_duty1");
        bus_read(8'h06, 32'h40, "rd_duty1_lowbits_ignored");
        bus_read(8'h40, 32'h1, "rd_ctrl");
        bus_read(8'h44, 32'h0, "rd_presc");
        bus_write(8'h50, 32'hDEAD);
        bus_read(8'h50, 32'h0, "rd_unmapped_50");
        bus_write(8'h10, 32'h55);
        bus_read(8'h10, 32'h0, "rd_oor_ch4");
        bus_read(8'h4C, 32'h0, "rd_fade_absent");

        bus_write(8'h08, 32'hFF);
        wait_tick("ch2_full");
        measure(256);
        check("ch2_full_on", 32'(on_cnt[2]), 32'd256);
        check("ch1_still_64", 32'(on_cnt[1]), 32'd64);
        check("ticks_256", 32'(tick_cnt), 32'd1);

        wait_tick("status");
        bus_read(8'h48, 32'h00, "status_0");
        bus_read(8'h48, 32'h01, "status_1");
        wait_tick("status_wrap");
        repeat (254) @(negedge clk);
        bus_read(8'h48, 32'hFE, "status_fe");
        bus_read(8'h48, 32'hFF, "status_ff");
        bus_read(8'h48, 32'h00, "status_wrap_00");

        wait_tick("glitch");
        two_periods(15, 32'h20);
        check("glitch_cur_period", 32'(per[0]), 32'd128);
        check("glitch_next_period", 32'(per[1]), 32'd32);
        wait_tick("bypass");
        two_periods(254, 32'h60);
        check("bypass_prev_period", 32'(per[0]), 32'd32);
        check("bypass_wrap_write", 32'(per[1]), 32'd96);
        bus_read(8'h0C, 32'h60, "rd_duty3_shadow");

        bus_write(8'h44, 32'h3);
        wait_tick("presc");
        bus_read(8'h48, 32'h0, "presc_hold_0");
        bus_read(8'h48, 32'h0, "presc_hold_1");
        bus_read(8'h48, 32'h0, "presc_hold_2");
        bus_read(8'h48, 32'h0, "presc_hold_3");
        bus_read(8'h48, 32'h1, "presc_advance");
        wait_tick("presc_period");
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (period_tick !== 1'b1 && gap < 3000);
        check("presc_period_1024", 32'(gap), 32'd1024);

        bus_write(8'h40, 32'h0);
        @(negedge clk);
        check("en_off_pwm", 32'(pwm_out), 32'hF);
        measure(1100);
        check("en_off_ch0_never_on", 32'(on_cnt[0]), 32'd0);
        check("en_off_no_ticks", 32'(tick_cnt), 32'd0);
        bus_read(8'h48, 32'h0, "en_off_status");
        bus_write(8'h04, 32'h11);
        bus_read(8'h04, 32'h11, "en_off_write_accepted");

        bus_write(8'h00, 32'h80);
        bus_write(8'h40, 32'h1);
        wait_tick("pre_reset");
        repeat (8) @(negedge clk);
        bus_read(8'h00, 32'h80, "rd_duty0_pre_reset");
        @(negedge clk);
        check("pre_reset_ch0_on", 32'(pwm_out[0]), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("midrun_reset_pwm", 32'(pwm_out), 32'hF);
        check("midrun_reset_rdata", rdata, 32'd0);
        check("midrun_reset_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_read(8'h00, 32'h0, "post_reset_duty0");
        bus_read(8'h40, 32'h0, "post_reset_ctrl");
        bus_read(8'h44, 32'h0, "post_reset_presc");
        bus_read(8'h48, 32'h0, "post_reset_status");
        measure(300);
        check("post_reset_ch0_off", 32'(on_cnt[0]), 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
